ct_split: RTL and testbench

- Packet demultiplexer: one input stream fans out to RADIX output streams. It is the receive-side counterpart of the merge arbiter and consumes the merged stream it produces.
- Destination index is taken from a field of the packet's head beat. The route is held until the EOP beat is accepted, so packets are never interleaved across outputs.
- Single registered output stage: 1-cycle latency, full throughput.
- Out-of-range destinations are discarded and flagged on o_drop.

---
 rtl/ct_split.sv | 121 ++++++++++++
 tb/tb_ct_split.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ct_split.sv
// ct_split: packet demultiplexer. A single input stream is routed to one of
// RADIX outputs, chosen by the destination field of each packet's head beat.
// The route is held until the EOP beat is accepted. Heads that name a
// nonexistent output are discarded together with the rest of their packet,
// and each such packet raises a one-cycle o_drop pulse.
module ct_split #(
  parameter int RADIX     = 2,
  parameter int WIDTH     = 8,
  parameter int EOP       = 0,
  parameter int DEST_LSB  = 1,
  parameter int DEST_BITS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [RADIX*WIDTH-1:0] o_data,
  output logic [RADIX-1:0]       o_valid,
  input  logic [RADIX-1:0]       i_ready,
  output logic                   o_drop
);

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // One extra bit so that RADIX == 2**DEST_BITS still compares correctly.
  localparam logic [DEST_BITS:0] RADIX_W = RADIX[DEST_BITS:0];

  state_t               state;
  logic [DEST_BITS-1:0] cur_dest;
  logic [DEST_BITS-1:0] out_dest;
  logic [WIDTH-1:0]     out_data;
  logic                 out_vld;

  logic [DEST_BITS-1:0] hdest;
  logic [DEST_BITS-1:0] route;
  logic                 heop;
  logic                 bad;
  logic                 accept;
  logic                 sel_ready;
  logic                 fwd;
  logic                 drain;

  assign hdest  = i_data[DEST_LSB +: DEST_BITS];
  assign heop   = i_data[EOP];
  assign bad    = ({1'b0, hdest} >= RADIX_W);
  assign route  = (state == S_HEAD) ? hdest : cur_dest;
  assign accept = i_valid && o_ready;

  // Only the ready of the output currently holding the beat matters.
  always_comb begin
    sel_ready = 1'b0;
    for (int unsigned k = 0; k < RADIX; k++) begin
      if (out_dest == DEST_BITS'(k)) sel_ready = i_ready[k];
    end
  end

  assign drain = out_vld && sel_ready;

  // Discarding beats never touches the output register, so they are always
  // accepted; otherwise the input waits for the output slot to free up.
  assign o_ready = (state == S_DROP) || ((state == S_HEAD) && bad) ||
                   !out_vld || sel_ready;

  assign fwd = accept && ((state == S_BODY) || ((state == S_HEAD) && !bad));

  // One-hot valid decode from the registered destination.
  always_comb begin
    o_valid = '0;
    for (int unsigned k = 0; k < RADIX; k++) begin
      o_valid[k] = out_vld && (out_dest == DEST_BITS'(k));
    end
  end

  assign o_data = {RADIX{out_data}};

  // Packet FSM, output register and drop pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_HEAD;
      cur_dest <= '0;
      out_data <= '0;
      out_dest <= '0;
      out_vld  <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      o_drop <= accept && (state == S_HEAD) && bad;

      // A load in the same cycle as a drain replaces the beat, so there is no bubble.
      if (fwd) begin
        out_data <= i_data;
        out_dest <= route;
        out_vld  <= 1'b1;
      end else if (drain) begin
        out_vld <= 1'b0;
      end

      if (accept) begin
        case (state)
          S_HEAD: begin
            if (bad) begin
              state <= heop ? S_HEAD : S_DROP;
            end else if (!heop) begin
              state    <= S_BODY;
              cur_dest <= hdest;
            end
          end
          S_BODY, S_DROP: begin
            if (heop) state <= S_HEAD;
          end
          default: state <= S_HEAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ct_split.sv
// Bench for ct_split (RADIX=3, WIDTH=8, EOP=0, DEST_LSB=1, DEST_BITS=2).
// A packet-level model runs beside the DUT and is compared on every negedge;
// directed sequences with literal expectations pin the model.
module tb_ct_split;

  localparam int RADIX = 3;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   reset;
  logic [WIDTH-1:0]       i_data;
  logic                   i_valid;
  logic                   o_ready;
  logic [RADIX*WIDTH-1:0] o_data;
  logic [RADIX-1:0]       o_valid;
  logic [RADIX-1:0]       i_ready;
  logic                   o_drop;

  int n_cmp = 0;
  int n_err = 0;

  ct_split #(
    .RADIX    (RADIX),
    .WIDTH    (WIDTH),
    .EOP      (0),
    .DEST_LSB (1),
    .DEST_BITS(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_drop (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the beat waiting at the outputs (if any), and what the next
  // accepted input beat means: -1 = a new packet head, 0..RADIX-1 = body of a
  // packet going to that output, RADIX = body of a packet being thrown away.
  bit         m_vld;
  logic [1:0] m_dest;
  logic [7:0] m_data;
  bit         m_drop;
  int         m_mode;

  always @(negedge clk) begin
    int  hd;
    bit  eop, exp_ready, acc, slot_free;
    if (!reset) begin
      m_vld = 0; m_dest = 0; m_data = 0; m_drop = 0; m_mode = -1;
    end else begin
      hd        = int'(i_data[2:1]);
      eop       = i_data[0];
      slot_free = !m_vld || i_ready[m_dest];
      exp_ready = (m_mode == RADIX) || (m_mode < 0 && hd >= RADIX) || slot_free;

      check("o_valid", 32'(o_valid), m_vld ? 32'(1) << m_dest : 32'd0);
      check("o_data",  32'(o_data),  32'({3{m_data}}));
      check("o_ready", 32'(o_ready), 32'(exp_ready));
      check("o_drop",  32'(o_drop),  32'(m_drop));

      acc    = i_valid && exp_ready;
      m_drop = 0;
      if (m_vld && i_ready[m_dest]) m_vld = 0;
      if (acc) begin
        if (m_mode < 0 && hd >= RADIX) begin
          m_drop = 1;
          m_mode = eop ? -1 : RADIX;
        end else if (m_mode == RADIX) begin
          if (eop) m_mode = -1;
        end else begin
          m_vld  = 1;
          m_data = i_data;
          m_dest = (m_mode < 0) ? 2'(hd) : 2'(m_mode);
          m_mode = eop ? -1 : int'(m_dest);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    i_data  = d;
    i_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] pkt [4];
  logic [2:0] pv  [4];

  initial begin
    reset   = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data",  32'(o_data),  32'd0);
    check("rst_o_drop",  32'(o_drop),  32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);

    // Single beat to output 2
    i_data = 8'h05; i_valid = 1'b1;
    #1 check("single_ready", 32'(o_ready), 32'd1);
    tick();
    check("single_valid", 32'(o_valid), 32'b100);
    check("single_data",  32'(o_data[23:16]), 32'h05);
    idle(2);

    // 3-beat packet to output 1 then single beat to output 0, back to back
    pkt[0] = 8'h02; pkt[1] = 8'h7E; pkt[2] = 8'hF1; pkt[3] = 8'h01;
    pv[0]  = 3'b010; pv[1] = 3'b010; pv[2] = 3'b010; pv[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      send(pkt[i]);
      check("pkt_valid", 32'(o_valid), 32'(pv[i]));
    end
    idle(2);

    // Backpressure on output 1; ready of output 0 toggles meanwhile
    i_ready = 3'b101;
    send(8'h03);
    check("bp_valid0", 32'(o_valid), 32'b010);
    i_data = 8'h05; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_ready[0] = i[0];
      #1;
      check("bp_ready",  32'(o_ready), 32'd0);
      check("bp_valid",  32'(o_valid), 32'b010);
      check("bp_data",   32'(o_data[15:8]), 32'h03);
      tick();
    end
    i_ready = 3'b111;
    #1 check("bp_release_ready", 32'(o_ready), 32'd1);
    tick();
    check("bp_next_valid", 32'(o_valid), 32'b100);
    check("bp_next_data",  32'(o_data[23:16]), 32'h05);
    idle(2);

    // Bad destination packet, then a good beat to output 1
    pkt[0] = 8'h06; pkt[1] = 8'h10; pkt[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      i_data = pkt[i]; i_valid = 1'b1;
      #1 check("bad_ready", 32'(o_ready), 32'd1);
      tick();
      check("bad_valid", 32'(o_valid), 32'd0);
      check("bad_drop",  32'(o_drop), (i == 0) ? 32'd1 : 32'd0);
    end
    send(8'h03);
    check("after_bad_valid", 32'(o_valid), 32'b010);
    check("after_bad_drop",  32'(o_drop),  32'd0);
    idle(2);

    // Reset mid-packet with a beat held at the output
    i_ready = 3'b000;
    send(8'h02);
    i_valid = 1'b0;
    check("mid_valid_pre", 32'(o_valid), 32'b010);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_drop",  32'(o_drop),  32'd0);
    tick();
    tick();
    reset   = 1'b1;
    i_ready = 3'b111;
    tick();
    send(8'h04);
    check("mid_head_valid", 32'(o_valid), 32'b100);
    check("mid_head_data",  32'(o_data[23:16]), 32'h04);
    send(8'h09);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 8'($urandom);
      i_ready = 3'($urandom) | (($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000);
      tick();
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
